// File: rtl/truth_table_scanner.sv
// Truth-table scanner: drives ABC through 000..111, samples F after a settle delay,
// builds the 8-entry table, and flags pass when it matches EXPECTED.
module truth_table_scanner #(
   parameter int         TICK_DIV      = 100_000_000,
   parameter int         DB_CYCLES     = 2_000_000,
   parameter int         SETTLE_CYCLES = 2,
   parameter logic [7:0] EXPECTED      = 8'h7E
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  sw_pin,
   input  logic        btn_pin,
   output logic [2:0]  abc_out,
   input  logic        f_in,
   output logic [15:0] led_pin
);

   localparam int TICK_W   = $clog2(TICK_DIV + 1);
   localparam int DB_W     = $clog2(DB_CYCLES + 1);
   localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_DIV - 1);
   localparam logic [DB_W-1:0]     DB_LAST     = DB_W'(DB_CYCLES - 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_APPLY  = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_SAMPLE = 3'd3;
   localparam logic [2:0] ST_WAIT   = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   logic                r_btn_meta;
   logic                r_btn_sync;
   logic                r_btn_stable;
   logic                r_btn_prev;
   logic [DB_W-1:0]     r_db_cnt;

   logic [2:0]          r_state;
   logic [2:0]          r_idx;
   logic [2:0]          r_abc;
   logic [7:0]          r_table;
   logic                r_done;
   logic                r_busy;
   logic                r_pass;
   logic [SETTLE_W-1:0] r_settle_cnt;
   logic [TICK_W-1:0]   r_tick_cnt;

   logic                w_press;
   logic                w_auto;
   logic                w_advance;
   logic [2:0]          w_state_nxt;
   logic                w_busy_nxt;
   logic [7:0]          w_table_upd;
   logic                w_unused_sw;

   assign w_unused_sw = ^sw_pin[6:0];
   assign w_auto      = sw_pin[7];
   assign w_press     = r_btn_stable & ~r_btn_prev;

   // Two-flop synchroniser, then a level is accepted only after DB_CYCLES
   // consecutive samples that disagree with the currently accepted level.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         r_btn_meta   <= 1'b0;
         r_btn_sync   <= 1'b0;
         r_btn_stable <= 1'b0;
         r_btn_prev   <= 1'b0;
         r_db_cnt     <= '0;
      end else begin
         r_btn_meta <= btn_pin;
         r_btn_sync <= r_btn_meta;
         r_btn_prev <= r_btn_stable;
         if (r_btn_sync == r_btn_stable) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_btn_stable <= r_btn_sync;
            r_db_cnt     <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case can leave it unassigned and infer a latch.
      w_state_nxt = r_state;
      w_advance   = w_auto ? (r_tick_cnt == TICK_LAST) : w_press;
      w_table_upd = r_table;
      w_table_upd[r_idx] = f_in;
      case (r_state)
         ST_IDLE, ST_DONE: if (w_press) w_state_nxt = ST_APPLY;
         ST_APPLY:         w_state_nxt = ST_SETTLE;
         ST_SETTLE:        if (r_settle_cnt == SETTLE_LAST) w_state_nxt = ST_SAMPLE;
         ST_SAMPLE:        w_state_nxt = (r_idx == 3'd7) ? ST_DONE : ST_WAIT;
         ST_WAIT:          if (w_advance) w_state_nxt = ST_APPLY;
         default:          w_state_nxt = ST_IDLE;
      endcase
      w_busy_nxt = (w_state_nxt == ST_APPLY) || (w_state_nxt == ST_SETTLE) ||
                   (w_state_nxt == ST_SAMPLE) || (w_state_nxt == ST_WAIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_idx        <= 3'd0;
         r_abc        <= 3'd0;
         r_table      <= 8'h00;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
         r_pass       <= 1'b0;
         r_settle_cnt <= '0;
         r_tick_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_busy_nxt;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_press) begin
                  r_idx   <= 3'd0;
                  r_table <= 8'h00;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
               end
            end
            ST_APPLY: begin
               r_abc        <= r_idx;
               r_settle_cnt <= '0;
            end
            ST_SETTLE: r_settle_cnt <= r_settle_cnt + 1'b1;
            ST_SAMPLE: begin
               r_table    <= w_table_upd;
               r_tick_cnt <= '0;
               if (r_idx == 3'd7) begin
                  r_done <= 1'b1;
                  r_pass <= (w_table_upd == EXPECTED);
               end
            end
            ST_WAIT: begin
               // Tick counter only runs in auto mode; manual waits hold it.
               if (w_auto) r_tick_cnt <= r_tick_cnt + 1'b1;
               if (w_advance) r_idx <= r_idx + 3'd1;
            end
            default: ;
         endcase
      end
   end

   assign abc_out = r_abc;
   assign led_pin = {r_table, r_done, r_busy, 1'b0, r_pass, f_in, r_abc};

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: table-driven full scans plus
// hand-written reset, bounce, dropped-press and restart sequences.
module tb_truth_table_scanner;

   localparam int TICK_DIV      = 10;
   localparam int DB_CYCLES     = 4;
   localparam int SETTLE_CYCLES = 2;
   localparam int SPACING       = TICK_DIV + SETTLE_CYCLES + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  sw_pin = 8'h00;
   logic        btn_pin = 1'b0;
   logic [2:0]  abc_out;
   logic        f_in;
   logic [15:0] led_pin;

   int f_kind = 2;
   int n_tests = 0;
   int n_fail  = 0;

   // Function models: 0 not-all-equal, 1 const 1, 2 const 0, 3 majority, 4 parity
   function automatic logic f_model(input int kind, input logic [2:0] abc);
      case (kind)
         0:       return (abc != 3'b000) && (abc != 3'b111);
         1:       return 1'b1;
         3:       return (abc[2] & abc[1]) | (abc[2] & abc[0]) | (abc[1] & abc[0]);
         4:       return ^abc;
         default: return 1'b0;
      endcase
   endfunction

   assign f_in = f_model(f_kind, abc_out);

   truth_table_scanner #(
      .TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES),
      .SETTLE_CYCLES(SETTLE_CYCLES), .EXPECTED(8'h7E)
   ) dut (
      .clk(clk), .rst(rst), .sw_pin(sw_pin), .btn_pin(btn_pin),
      .abc_out(abc_out), .f_in(f_in), .led_pin(led_pin)
   );

   always #5 clk = ~clk;

   // abc_out change monitor
   logic       mon_en = 1'b0;
   logic [2:0] mon_last = 3'd0;
   int         cyc = 0;
   logic [2:0] seq_val[$];
   int         seq_cyc[$];

   always @(negedge clk) begin
      cyc++;
      if (mon_en && abc_out != mon_last) begin
         seq_val.push_back(abc_out);
         seq_cyc.push_back(cyc);
      end
      mon_last = abc_out;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      btn_pin = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic press();
      btn_pin = 1'b1;
      repeat (10) @(negedge clk);
      btn_pin = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic wait_led_bit(input int bitn, input logic val, input int budget, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (led_pin[bitn] !== val && n < budget);
      check(name, led_pin[bitn], val);
   endtask

   task automatic wait_abc(input logic [2:0] val, input int budget, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (abc_out !== val && n < budget);
      check(name, abc_out, val);
   endtask

   typedef struct {
      string       name;
      logic        auto_mode;
      int          kind;
      logic [15:0] exp_led;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int bad;
      int seen;

      vecs[0] = '{"auto nae",      1'b1, 0, 16'h7E97};
      vecs[1] = '{"manual const1", 1'b0, 1, 16'hFF8F};
      vecs[2] = '{"auto const0",   1'b1, 2, 16'h0087};
      vecs[3] = '{"manual major",  1'b0, 3, 16'hE88F};
      vecs[4] = '{"auto parity",   1'b1, 4, 16'h968F};

      // Reset state, with led[3] following f_in live
      f_kind = 2;
      repeat (3) @(negedge clk);
      check("reset abc", abc_out, 3'd0);
      check("reset led f0", led_pin, 16'h0000);
      f_kind = 1;
      #1;
      check("reset led f1", led_pin, 16'h0008);
      f_kind = 2;
      rst = 1'b0;
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         seen |= led_pin;
      end
      check("idle no press", seen, 0);

      // Table-driven full scans
      for (int v = 0; v < 5; v++) begin
         do_reset();
         sw_pin = vecs[v].auto_mode ? 8'hFF : 8'h7F;
         f_kind = vecs[v].kind;
         seq_val.delete();
         seq_cyc.delete();
         mon_en = 1'b1;
         if (vecs[v].auto_mode) press();
         else repeat (8) press();
         wait_led_bit(7, 1'b1, 600, {vecs[v].name, " done"});
         mon_en = 1'b0;
         check({vecs[v].name, " led"}, led_pin, vecs[v].exp_led);
         check({vecs[v].name, " steps"}, seq_val.size(), 7);
         bad = 0;
         foreach (seq_val[i]) if (seq_val[i] != 3'(i + 1)) bad++;
         check({vecs[v].name, " order"}, bad, 0);
         if (vecs[v].auto_mode) begin
            bad = 0;
            for (int i = 1; i < seq_cyc.size(); i++)
               if (seq_cyc[i] - seq_cyc[i-1] != SPACING) bad++;
            check({vecs[v].name, " spacing"}, bad, 0);
         end
      end

      // Restart from DONE after the passing scan
      do_reset();
      sw_pin = 8'h80;
      f_kind = 0;
      press();
      wait_led_bit(7, 1'b1, 400, "first scan done");
      check("first scan led", led_pin, 16'h7E97);
      btn_pin = 1'b1;
      wait_led_bit(6, 1'b1, 30, "restart busy");
      check("restart cleared", {led_pin[15:7], led_pin[4]}, 10'h000);
      @(negedge clk);
      check("restart abc", abc_out, 3'd0);
      repeat (6) @(negedge clk);
      btn_pin = 1'b0;
      wait_led_bit(7, 1'b1, 400, "second scan done");
      check("second scan led", led_pin, 16'h7E97);

      // Bounce rejection
      do_reset();
      sw_pin = 8'h00;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         btn_pin = ~btn_pin;
         repeat (2) begin
            @(negedge clk);
            seen |= led_pin[6];
         end
      end
      btn_pin = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen |= led_pin[6];
      end
      check("bounce no busy", seen, 0);
      check("bounce led", led_pin, 16'h0000);

      // Reset mid-scan, then restart from idx 0
      do_reset();
      sw_pin = 8'h80;
      f_kind = 0;
      press();
      wait_abc(3'd4, 200, "midscan reach 4");
      rst = 1'b1;
      @(negedge clk);
      check("midscan abc", abc_out, 3'd0);
      check("midscan led", led_pin[15:4], 12'h000);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("midscan idle", {led_pin[6], abc_out}, 4'h0);
      seq_val.delete();
      mon_en = 1'b1;
      press();
      wait_led_bit(7, 1'b1, 400, "midscan rescan done");
      mon_en = 1'b0;
      check("midscan rescan led", led_pin, 16'h7E97);
      check("midscan rescan steps", seq_val.size(), 7);

      // Step press landing in SETTLE is dropped, not queued
      do_reset();
      sw_pin = 8'h80;
      f_kind = 1;
      press();
      wait_abc(3'd2, 200, "settle reach 2");
      repeat (8) @(negedge clk);
      btn_pin = 1'b1;
      wait_abc(3'd3, 20, "settle reach 3");
      sw_pin = 8'h00;
      repeat (40) @(negedge clk);
      check("settle press dropped", abc_out, 3'd3);
      check("settle still busy", led_pin[7:6], 2'b01);
      btn_pin = 1'b0;
      repeat (15) @(negedge clk);
      repeat (4) press();
      wait_led_bit(7, 1'b1, 200, "settle scan done");
      check("settle scan led", led_pin, 16'hFF8F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus/capture engine for 3-input combinational functions on the EGO1 board.
- Sweeps ABC through 000..111 on abc_out and samples the function output F on f_in after a settle time.
- Builds the 8-entry truth table, shows it on the LEDs, and flags pass when it matches an expected table.
- Scan advance is automatic (timed) or manual (debounced button step).

Parameters:
- TICK_DIV, 100_000_000, cycles between vectors in auto mode (1 s at 100 MHz); must be >= 1.
- DB_CYCLES, 2_000_000, cycles btn_pin must be stable before it is accepted (20 ms).
- SETTLE_CYCLES, 2, cycles waited after driving abc_out before sampling f_in; must be >= 1.
- EXPECTED, 8'h7E, expected truth table; bit i = F for ABC = i.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous active-high reset
- sw_pin  input  8  board switches; sw_pin[7] = mode (1 auto, 0 manual); others unused
- btn_pin  input  1  start/step push-button, asynchronous and bouncy
- abc_out  output  3  vector to function under test; [2]=A, [1]=B, [0]=C
- f_in  input  1  F from function under test, combinational
- led_pin  output  16  [15:8] captured table, [7] done, [6] busy, [5] 0, [4] pass, [3] live f_in, [2:0] abc_out

Behaviour:
- Reset (rst=1 on a clk edge):
  - All regs cleared.
  - abc_out = 0, table = 0, done = busy = pass = 0.
  - led_pin = {8'h00, 4'b0000, f_in, 3'b000}; f_in passes through live, so led_pin[3] mirrors the function output at all times.
  - Reset mid-scan aborts the scan; no partial table is retained.
- Button conditioning:
  - btn_pin passes through a 2-FF synchroniser.
  - Stable counter: accept a new level only after DB_CYCLES consecutive equal samples.
  - Rising edge of the accepted level produces a one-cycle press pulse.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, WAIT, DONE.
  - IDLE: busy=0. press -> APPLY with idx=0, table cleared.
  - APPLY: abc_out <= idx (registered; visible the next cycle); settle counter cleared; -> SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles -> SAMPLE.
  - SAMPLE: table[idx] <= f_in.
    - idx==7 -> DONE.
    - Otherwise -> WAIT, tick counter cleared.
  - WAIT: mode is read every cycle; a switch change takes effect immediately.
    - Auto: after TICK_DIV cycles in WAIT, idx <= idx+1 -> APPLY.
    - Manual: press -> idx+1 -> APPLY.
    - A press in auto mode is ignored.
  - DONE: busy=0, done=1, pass = (table == EXPECTED); abc_out holds 3'b111. press -> clear table/done/pass, idx=0 -> APPLY.
- busy=1 in APPLY, SETTLE, SAMPLE and WAIT.
- Presses in APPLY/SETTLE/SAMPLE are dropped (not queued).
- idx is 3 bits and never wraps inside a scan; termination is at idx==7 only.
- Timing: press pulse at cycle t -> FSM in APPLY at t+1 -> new abc_out visible from t+2 -> f_in sampled at the SAMPLE edge SETTLE_CYCLES+1 cycles later.
- table bits for not-yet-sampled indices read 0 while busy.
- All outputs are registered except led_pin[3].

Test Plan:
(Bench parameters: TICK_DIV=10, DB_CYCLES=4, SETTLE_CYCLES=2; f_in model = not-all-equal of abc_out unless stated.)
- Reset: hold rst 3 cycles with f_in=0 -> abc_out=0, led_pin=16'h0000; release with no press -> stays 16'h0000 for 100 cycles.
- Auto full scan: sw_pin[7]=1, clean press of 10 cycles -> abc_out steps 0..7 at 10-cycle spacing in WAIT -> final led_pin=16'h7E97 (table 7E, done, pass, F(111)=0, abc=7).
- Manual scan, wrong function: sw_pin[7]=0, f_in tied 1, one start press plus 7 step presses -> table 8'hFF, done=1, pass=0, led_pin=16'hFF8F; a step press during SETTLE causes no extra advance.
- Bounce rejection: toggle btn_pin every 2 cycles for 30 cycles, then settle low -> no press pulse, FSM stays IDLE, abc_out=0.
- Reset mid-scan: auto scan, assert rst while abc_out=4 -> next cycle abc_out=0, led_pin[15:4]=0, FSM IDLE; a subsequent press restarts from idx 0.
- Restart from DONE: after the passing scan, press -> done=pass=0, table=0, busy=1, abc_out returns to 0 and a second scan again ends with led_pin=16'h7E97.
